// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates a single byte-wide RAM port between the instruction
// fetch stage and MEM-stage loads/stores, serialising 32-bit words little-endian.
module mem_port_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              addr_needed,
    input  logic [ADDR_W-1:0] pc_mem,
    output logic              inst_available,
    output logic [31:0]       inst_in,
    output logic [ADDR_W-1:0] pc_back,
    output logic [1:0]        memcnf,
    input  logic              branch_interception,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [3:0] {IDLE, F0, F1, F2, F3, F4, DR, DW} state_t;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              guard_q, guard_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       ibuf_q, ibuf_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] pcb_q, pcb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] rama_q;

    logic              isFetch;
    logic              isData;
    logic              addrNeeded;
    logic              memAccept;
    logic [2:0]        lenNorm;
    logic [ADDR_W-1:0] ramA;
    logic              ramWr;
    logic [7:0]        ramDout;
    logic              instAvail;
    logic              memDone;
    logic [31:0]       instOut;
    logic [ADDR_W-1:0] pcbOut;
    logic [31:0]       rdataOut;

    assign isFetch    = state_q inside {F0, F1, F2, F3, F4};
    assign isData     = state_q inside {DR, DW};
    assign addrNeeded = (state_q == IDLE) && !mem_req && !guard_q;
    assign memAccept  = (state_q == IDLE) && mem_req && !guard_q;

    // Any length other than a byte or half-word is handled as a full word
    always_comb begin
        case (mem_len)
            3'd1:    lenNorm = 3'd1;
            3'd2:    lenNorm = 3'd2;
            default: lenNorm = 3'd4;
        endcase
    end

    // Next-state logic plus the RAM port and result datapath for every state
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        guard_d   = 1'b0;
        pc_d      = pc_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        ibuf_d    = ibuf_q;
        rbuf_d    = rbuf_q;
        inst_d    = inst_q;
        pcb_d     = pcb_q;
        rdata_d   = rdata_q;
        ramA      = rama_q;
        ramWr     = 1'b0;
        ramDout   = 8'h00;
        instAvail = 1'b0;
        memDone   = 1'b0;
        instOut   = inst_q;
        pcbOut    = pcb_q;
        rdataOut  = rdata_q;

        case (state_q)
            IDLE: begin
                if (memAccept) begin
                    addr_d  = mem_addr;
                    len_d   = lenNorm;
                    wdata_d = mem_wdata;
                    rbuf_d  = 32'h0;
                    k_d     = 3'd0;
                    state_d = mem_we ? DW : DR;
                end else if (addrNeeded && !branch_interception) begin
                    pc_d    = pc_mem;
                    state_d = F0;
                end
            end
            F0: begin
                ramA    = pc_q;
                state_d = F1;
            end
            F1: begin
                ramA         = pc_q + ADDR_W'(1);
                ibuf_d[7:0]  = ram_din;
                state_d      = F2;
            end
            F2: begin
                ramA         = pc_q + ADDR_W'(2);
                ibuf_d[15:8] = ram_din;
                state_d      = F3;
            end
            F3: begin
                ramA          = pc_q + ADDR_W'(3);
                ibuf_d[23:16] = ram_din;
                state_d       = F4;
            end
            F4: begin
                state_d = IDLE;
                if (!branch_interception) begin
                    instAvail = 1'b1;
                    instOut   = {ram_din, ibuf_q};
                    pcbOut    = pc_q;
                    inst_d    = {ram_din, ibuf_q};
                    pcb_d     = pc_q;
                end
            end
            DR: begin
                if (k_q < len_q) begin
                    ramA = addr_q + ADDR_W'(k_q);
                end
                for (int b = 0; b < 4; b++) begin
                    if (k_q == 3'(b + 1)) begin
                        rbuf_d[8*b +: 8] = ram_din;
                    end
                end
                if (k_q == len_q) begin
                    memDone  = 1'b1;
                    rdataOut = rbuf_d;
                    rdata_d  = rbuf_d;
                    state_d  = IDLE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DW: begin
                ramA  = addr_q + ADDR_W'(k_q);
                ramWr = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (k_q == 3'(b)) begin
                        ramDout = wdata_q[8*b +: 8];
                    end
                end
                if (k_q == len_q - 3'd1) begin
                    memDone = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (isFetch && branch_interception) begin
            state_d = IDLE;
        end

        guard_d = memDone;
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            guard_q <= 1'b0;
            pc_q    <= '0;
            addr_q  <= '0;
            len_q   <= 3'd0;
            wdata_q <= 32'h0;
            ibuf_q  <= 24'h0;
            rbuf_q  <= 32'h0;
            inst_q  <= 32'h0;
            pcb_q   <= '0;
            rdata_q <= 32'h0;
            rama_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            guard_q <= guard_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            ibuf_q  <= ibuf_d;
            rbuf_q  <= rbuf_d;
            inst_q  <= inst_d;
            pcb_q   <= pcb_d;
            rdata_q <= rdata_d;
            rama_q  <= ramA;
        end
    end

    assign addr_needed    = addrNeeded && !rst;
    assign inst_available = instAvail && !rst;
    assign inst_in        = rst ? 32'h0 : instOut;
    assign pc_back        = rst ? '0 : pcbOut;
    assign memcnf[0]      = !rst && (isData || memAccept);
    assign memcnf[1]      = !rst && mem_req && isFetch;
    assign mem_done       = memDone && !rst;
    assign mem_rdata      = rst ? 32'h0 : rdataOut;
    assign ram_a          = rst ? '0 : ramA;
    assign ram_wr         = ramWr && !rst;
    assign ram_dout       = rst ? 8'h00 : ramDout;

endmodule
